// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one imem request at a time,
// presents the fetched word to decode and computes the next PC on accept.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instr,
   output logic        instr_valid,
   input  logic        core_ready,
   input  logic        PCSrc,
   input  logic [31:0] ImmExt,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        fault,
   output logic [31:0] instr_count
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_VALID,
      S_FAULT
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] instr_q;
   logic        fault_q;
   logic [31:0] next_pc;

   // Branch target and sequential PC share one adder; both wrap mod 2^32.
   assign next_pc = pc + (PCSrc ? ImmExt : 32'd4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_BOOT;
         pc          <= RESET_PC;
         instr_q     <= 32'h0000_0000;
         fault_q     <= 1'b0;
         instr_count <= 32'h0000_0000;
      end else begin
         case (state)
            S_BOOT:  state <= S_REQ;
            S_REQ:   state <= S_WAIT;
            S_WAIT: begin
               if (imem_rvalid) begin
                  instr_q <= imem_rdata;
                  state   <= S_VALID;
               end
            end
            S_VALID: begin
               if (core_ready) begin
                  instr_count <= instr_count + 32'd1;
                  if (next_pc[1:0] == 2'b00) begin
                     pc    <= next_pc;
                     state <= S_REQ;
                  end else begin
                     fault_q <= 1'b1;
                     state   <= S_FAULT;
                  end
               end
            end
            S_FAULT: state <= S_FAULT;
            default: state <= S_BOOT;
         endcase
      end
   end

   // Moore outputs decoded from the registered state, so reset clears them at once.
   assign imem_req    = (state == S_REQ);
   assign instr_valid = (state == S_VALID);
   assign imem_addr   = pc;
   assign PC          = pc;
   assign PCPlus4     = pc + 32'd4;
   assign Instr       = instr_q;
   assign fault       = fault_q;

endmodule
